l2_cacheline_adapter: RTL and testbench

- Sits directly downstream of the L2 cache's dfp port and converts its 256-bit line requests into 64-bit burst transactions on the memory interface.
- Reads: issues one read command, collects 4 beats, then returns the assembled line with a single-cycle response.
- Writes: serialises the line into 4 write beats, then responds.
- Handles exactly one line transaction at a time.

---
 rtl/l2_cacheline_adapter.sv | 69 ++++++
 tb/tb_l2_cacheline_adapter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter: converts 256-bit L2 line requests into 64-bit memory bursts
module l2_cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ufp_addr,
  input  logic              ufp_read,
  input  logic              ufp_write,
  input  logic [LINE_W-1:0] ufp_wdata,
  output logic [LINE_W-1:0] ufp_rdata,
  output logic              ufp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);
  localparam int CW  = $clog2(BEATS);
  localparam int OFF = $clog2(LINE_W / 8);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic rd_q, wr_acc, rd_acc, last;
  always_comb begin
    wr_acc = state == WR_BURST && bmem_ready;
    rd_acc = state == RD_WAIT && bmem_rvalid && bmem_raddr[31:OFF] == addr_q[31:OFF];
    last = cnt == CW'(BEATS - 1);
    state_n = state;
    case (state)
      IDLE:     state_n = ufp_write ? WR_BURST : ufp_read ? RD_REQ : IDLE;
      RD_REQ:   state_n = bmem_ready ? RD_WAIT : RD_REQ;
      RD_WAIT:  state_n = rd_acc && last ? DONE : RD_WAIT;
      WR_BURST: state_n = wr_acc && last ? DONE : WR_BURST;
      default:  state_n = IDLE;
    endcase
    bmem_read = state == RD_REQ;
    bmem_write = state == WR_BURST;
    bmem_addr = (state == RD_REQ || state == WR_BURST) ? addr_q : '0;
    bmem_wdata = state == WR_BURST ? line_q[cnt*BEAT_W +: BEAT_W] : '0;
    ufp_resp = state == DONE;
    ufp_rdata = (state == DONE && rd_q) ? line_q : '0;
  end
  // line_q holds the outgoing write line or the incoming read beats
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      line_q <= '0;
      rd_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && (ufp_write || ufp_read)) begin
        addr_q <= {ufp_addr[31:OFF], {OFF{1'b0}}};
        rd_q <= !ufp_write;
      end
      if (state == IDLE && ufp_write) line_q <= ufp_wdata;
      if (rd_acc) line_q[cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
      if (wr_acc || rd_acc) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// tb_l2_cacheline_adapter: randomized bench with a behavioural memory and line-level expectations
module tb_l2_cacheline_adapter;
  logic clk, rst;
  logic [31:0] ufp_addr;
  logic ufp_read, ufp_write;
  logic [255:0] ufp_wdata, ufp_rdata;
  logic ufp_resp;
  logic [31:0] bmem_addr, bmem_raddr;
  logic bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0] bmem_wdata, bmem_rdata;

  l2_cacheline_adapter dut (
    .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_read(ufp_read), .ufp_write(ufp_write),
    .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp), .bmem_addr(bmem_addr),
    .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] exp_addr;
  logic [255:0] wline, rline;
  logic [63:0] wq[$];
  int ncmd, dk, stall, ready_mode;
  int stall_tab[4];
  bit dlv, fresh, junk_en, gap_en;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rep_line(input logic [7:0] base);
    logic [255:0] r;
    for (int i = 0; i < 4; i++) r[i*64 +: 64] = {8{base + 8'(i)}};
    return r;
  endfunction

  // one cycle: advance to the falling edge, then act as the memory for the next rising edge
  task automatic tick();
    int idx;
    @(negedge clk);
    bmem_rvalid = 0;
    bmem_raddr = 0;
    bmem_rdata = 0;
    if (dlv) begin
      if (junk_en && $urandom_range(2) == 0) begin
        bmem_rvalid = 1;
        bmem_raddr = exp_addr ^ 32'h0000_0C00;
        bmem_rdata = {$urandom, $urandom};
      end else if (!(gap_en && $urandom_range(2) == 0)) begin
        bmem_rvalid = 1;
        bmem_raddr = exp_addr | 32'($urandom_range(31));
        bmem_rdata = rline[dk*64 +: 64];
        dk++;
        if (dk == 4) dlv = 0;
      end
    end else if (junk_en && $urandom_range(3) == 0) begin
      bmem_rvalid = 1;
      bmem_raddr = exp_addr;
      bmem_rdata = {$urandom, $urandom};
    end
    if (bmem_read || bmem_write) begin
      if (fresh) begin
        stall = ready_mode == 0 ? 0 : ready_mode == 2 ? stall_tab[bmem_write ? (wq.size() > 3 ? 3 : wq.size()) : 0] : $urandom_range(2);
        fresh = 0;
      end
      checks++;
      if (bmem_addr !== exp_addr) begin errors++; $display("FAIL bmem_addr got %h want %h", bmem_addr, exp_addr); end
      checks++;
      if (bmem_read && bmem_write) begin errors++; $display("FAIL rd_wr_both got 1 want 0"); end
      if (bmem_write) begin
        idx = wq.size() > 3 ? 3 : wq.size();
        checks++;
        if (wq.size() > 3 || bmem_wdata !== wline[idx*64 +: 64]) begin
          errors++; $display("FAIL wdata beat %0d got %h want %h", wq.size(), bmem_wdata, wline[idx*64 +: 64]);
        end
      end
      bmem_ready = stall == 0;
      if (stall > 0) stall--;
      if (bmem_ready) begin
        fresh = 1;
        if (bmem_read) begin ncmd++; dlv = 1; dk = 0; end
        else wq.push_back(bmem_wdata);
      end
    end else bmem_ready = 1'($urandom_range(1));
  endtask

  task automatic xact(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] wl,
                      input logic [255:0] rl, input int exp_lat);
    int lat;
    bit seen;
    logic [255:0] got_w, want_r;
    tick();
    checks++;
    if (ufp_resp !== 0) begin errors++; $display("FAIL resp_idle got %b want 0", ufp_resp); end
    exp_addr = {a[31:5], 5'b0};
    wline = wl;
    rline = rl;
    wq.delete();
    ncmd = 0;
    fresh = 1;
    ufp_addr = a;
    ufp_write = wr;
    ufp_read = rd;
    ufp_wdata = wl;
    lat = 0;
    seen = 0;
    while (!seen && lat < 300) begin
      tick();
      lat++;
      if (ufp_resp) seen = 1;
      else begin
        ufp_addr = $urandom;
        ufp_wdata = rand256();
        checks++;
        if (ufp_rdata !== 0) begin errors++; $display("FAIL rdata_not_done got %h want 0", ufp_rdata); end
      end
    end
    ufp_read = 0;
    ufp_write = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL resp_timeout got none want resp"); end
    want_r = wr ? '0 : rl;
    checks++;
    if (ufp_rdata !== want_r) begin errors++; $display("FAIL ufp_rdata got %h want %h", ufp_rdata, want_r); end
    checks++;
    if (ncmd != (wr ? 0 : 1)) begin errors++; $display("FAIL read_cmds got %0d want %0d", ncmd, wr ? 0 : 1); end
    checks++;
    if (wq.size() != (wr ? 4 : 0)) begin errors++; $display("FAIL write_beats got %0d want %0d", wq.size(), wr ? 4 : 0); end
    else if (wr) begin
      got_w = {wq[3], wq[2], wq[1], wq[0]};
      checks++;
      if (got_w !== wl) begin errors++; $display("FAIL write_line got %h want %h", got_w, wl); end
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL latency got %0d want %0d", lat, exp_lat); end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    ufp_read = 1;
    ufp_write = 1;
    ufp_addr = 32'hFFFF_FFFF;
    ufp_wdata = rand256();
    repeat (3) begin
      tick();
      checks++;
      if ({bmem_read, bmem_write, bmem_addr, bmem_wdata, ufp_resp, ufp_rdata} !== 0) begin
        errors++; $display("FAIL reset_outputs got %b%b %h %h %b want all 0", bmem_read, bmem_write, bmem_addr, bmem_wdata, ufp_resp);
      end
    end
    rst = 0;
    ufp_read = 0;
    ufp_write = 0;
  endtask

  task automatic test_read_zero_wait();
    xact(0, 1, 32'h1234_5678, rand256(), rep_line(8'hA0), 6);
    checks++;
    if (exp_addr !== 32'h1234_5660) begin errors++; $display("FAIL read_line_addr got %h want 12345660", exp_addr); end
  endtask

  task automatic test_write_backpressure();
    ready_mode = 2;
    stall_tab = '{0, 2, 2, 0};
    xact(1, 0, 32'h0000_0A40, rep_line(8'hD0), rand256(), 9);
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    xact(1, 0, 32'h0000_0100, rand256(), rand256(), 5);
    xact(0, 1, 32'h0000_0200, rand256(), rand256(), 6);
  endtask

  task automatic test_mismatch();
    junk_en = 1;
    xact(0, 1, 32'h0000_0400, rand256(), rand256(), -1);
    junk_en = 0;
  endtask

  task automatic test_reset_mid_read();
    int n;
    tick();
    exp_addr = 32'h0000_0600;
    rline = rand256();
    fresh = 1;
    ufp_addr = 32'h0000_0600;
    ufp_read = 1;
    n = 0;
    while (!(dlv && dk == 2) && n < 50) begin tick(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL mid_read_timeout got %0d want <50", n); end
    tick();
    #1 rst = 1;
    ufp_read = 0;
    #1;
    checks++;
    if ({bmem_read, bmem_write, bmem_addr, bmem_wdata, ufp_resp, ufp_rdata} !== 0) begin
      errors++; $display("FAIL async_reset got %b%b %h %b want all 0", bmem_read, bmem_write, bmem_addr, ufp_resp);
    end
    tick();
    rst = 0;
    repeat (4) begin
      tick();
      checks++;
      if (ufp_resp !== 0 || bmem_read !== 0) begin
        errors++; $display("FAIL stray_after_reset got resp=%b read=%b want 0 0", ufp_resp, bmem_read);
      end
    end
    xact(0, 1, 32'h0000_0640, rand256(), rand256(), 6);
  endtask

  task automatic test_simultaneous();
    xact(1, 1, 32'h0000_0880, rand256(), rand256(), 5);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(2);
      ready_mode = $urandom_range(1);
      gap_en = 1'($urandom_range(1));
      junk_en = 1'($urandom_range(1));
      xact(op != 0, op != 1, $urandom, rand256(), rand256(), -1);
    end
    ready_mode = 0;
    gap_en = 0;
    junk_en = 0;
  endtask

  initial begin
    ufp_addr = 0; ufp_read = 0; ufp_write = 0; ufp_wdata = 0;
    bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
    exp_addr = 0; wline = 0; rline = 0;
    ncmd = 0; dk = 0; stall = 0; ready_mode = 0;
    dlv = 0; fresh = 1; junk_en = 0; gap_en = 0;
    test_reset();
    test_read_zero_wait();
    test_write_backpressure();
    test_back_to_back();
    test_mismatch();
    test_reset_mid_read();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
